// File: rtl/cost_pkg.sv
// Shared types and helpers for the squared-error cost engine.
package cost_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Ceiling log2, with a minimum of 1 bit so a 1-bit index always exists.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

    // Training target for one class: hot value on the labelled class, else zero.
    function automatic int unsigned target_val(input logic hot, input int unsigned hot_val);
        return hot ? hot_val : 32'd0;
    endfunction

endpackage

// File: rtl/sq_err_lane.sv
// Combinational error lane: absolute difference of target/confidence and the
// square of a (registered) difference with SQ_SHIFT LSBs dropped.
module sq_err_lane #(
    parameter int unsigned CONF_W   = 4,
    parameter int unsigned SQ_SHIFT = 2
) (
    input  logic [CONF_W-1:0]              i_tgt,
    input  logic [CONF_W-1:0]              i_conf,
    output logic [CONF_W-1:0]              o_diff,
    input  logic [CONF_W-1:0]              i_diff,
    output logic [2*CONF_W-SQ_SHIFT-1:0]   o_sq
);

    localparam int unsigned SQ_FULL_W = 2 * CONF_W;

    logic [SQ_FULL_W-1:0] w_full;

    assign o_diff = (i_tgt >= i_conf) ? (i_tgt - i_conf) : (i_conf - i_tgt);

    assign w_full = SQ_FULL_W'(i_diff) * SQ_FULL_W'(i_diff);
    assign o_sq   = w_full[SQ_FULL_W-1:SQ_SHIFT];

endmodule

// File: rtl/sq_error_cost_unit.sv
// Squared-error cost engine: snapshots confidences/label, streams one class per
// cycle through diff -> square -> accumulate, and tracks the argmax prediction.
// Define COST_SAT_EN for a saturating accumulator; default build wraps.
module sq_error_cost_unit
    import cost_pkg::*;
#(
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned CONF_W      = 4,
    parameter int unsigned SQ_SHIFT    = 2,
    parameter int unsigned ACC_W       = 8,
    parameter int unsigned TARGET_HOT  = 32'd1 << (CONF_W - 1)
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic                            start,
    input  logic [NUM_CLASSES-1:0]          expected_label,
    input  logic [NUM_CLASSES*CONF_W-1:0]   confidences,
    output logic                            busy,
    output logic                            done,
    output logic [ACC_W-1:0]                cost,
    output logic                            cost_ovf,
    output logic [clog2(NUM_CLASSES)-1:0]   pred_class,
    output logic                            pred_correct,
    output logic                            label_err
);

    localparam int unsigned       IDX_W    = clog2(NUM_CLASSES);
    localparam int unsigned       SQ_W     = 2 * CONF_W - SQ_SHIFT;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CLASSES - 1);
    localparam logic [ACC_W-1:0]  ACC_MAX  = '1;

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic                   w_accept;
    logic                   w_run;
    logic                   w_finish;

    logic [IDX_W-1:0]       r_idx;
    logic                   r_drain;
    logic [NUM_CLASSES-1:0] r_label;
    logic [CONF_W-1:0]      r_conf [NUM_CLASSES];

    logic [CONF_W-1:0]      w_conf_cur;
    logic [CONF_W-1:0]      w_tgt;
    logic [CONF_W-1:0]      w_diff;
    logic [SQ_W-1:0]        w_sq;
    logic [CONF_W-1:0]      r_diff;
    logic [ACC_W-1:0]       r_sq;
    logic                   r_v1;
    logic                   r_v2;

    logic [ACC_W-1:0]       r_acc;
    logic                   r_ovf;
    logic [ACC_W:0]         w_sum;

    logic [CONF_W-1:0]      r_max_val;
    logic [IDX_W-1:0]       r_max_idx;

    // FSM state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_run       = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_run = 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (r_drain) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_finish    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Class index and two-cycle drain timer
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_idx   <= '0;
            r_drain <= 1'b0;
        end else begin
            if (w_accept) begin
                r_idx <= '0;
            end else if (w_run) begin
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end
            r_drain <= (r_state == DRAIN) ? ~r_drain : 1'b0;
        end
    end

    // Snapshot of label and confidences; inputs are free to change afterwards
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_label <= '0;
            for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
                r_conf[i] <= '0;
            end
        end else if (w_accept) begin
            r_label <= expected_label;
            for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
                r_conf[i] <= confidences[i*CONF_W +: CONF_W];
            end
        end
    end

    assign w_conf_cur = r_conf[r_idx];
    assign w_tgt      = CONF_W'(target_val(r_label[r_idx], TARGET_HOT));

    sq_err_lane #(
        .CONF_W   (CONF_W),
        .SQ_SHIFT (SQ_SHIFT)
    ) u_lane (
        .i_tgt  (w_tgt),
        .i_conf (w_conf_cur),
        .o_diff (w_diff),
        .i_diff (r_diff),
        .o_sq   (w_sq)
    );

    // Stage 1 / stage 2 pipeline registers with valid tags
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_diff <= '0;
            r_sq   <= '0;
        end else begin
            r_v1   <= w_run;
            r_diff <= w_diff;
            r_v2   <= r_v1;
            r_sq   <= ACC_W'(w_sq);
        end
    end

    assign w_sum = {1'b0, r_acc} + {1'b0, r_sq};

    // Stage 3 accumulator; overflow flag is sticky for the run
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (r_v2) begin
`ifdef COST_SAT_EN
            if (w_sum[ACC_W]) begin
                r_acc <= ACC_MAX;
                r_ovf <= 1'b1;
            end else begin
                r_acc <= w_sum[ACC_W-1:0];
            end
`else
            r_acc <= w_sum[ACC_W-1:0];
            if (w_sum[ACC_W]) begin
                r_ovf <= 1'b1;
            end
`endif
        end
    end

    // Argmax in stage-1 order: only a strictly larger value moves the winner
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_max_val <= '0;
            r_max_idx <= '0;
        end else if (w_accept) begin
            r_max_val <= '0;
            r_max_idx <= '0;
        end else if (w_run && (w_conf_cur > r_max_val)) begin
            r_max_val <= w_conf_cur;
            r_max_idx <= r_idx;
        end
    end

    // Result registers: published with the done pulse, held until the next run ends
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            cost         <= '0;
            cost_ovf     <= 1'b0;
            pred_class   <= '0;
            pred_correct <= 1'b0;
            label_err    <= 1'b0;
        end else begin
            done <= w_finish;
            if (w_accept) begin
                busy <= 1'b1;
            end else if (done) begin
                busy <= 1'b0;
            end
            if (w_finish) begin
                cost         <= r_acc;
                cost_ovf     <= r_ovf;
                pred_class   <= r_max_idx;
                pred_correct <= r_label[r_max_idx];
                label_err    <= ($countones(r_label) != 1);
            end
        end
    end

endmodule
